// File: rtl/display_scan.sv
// rtl/display_scan.sv - four-digit multiplexed hex display scanner with frame-synchronous content update
module display_scan #(
  parameter int DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  point_in,
  input  logic [3:0]  le_in,
  input  logic        blank,
  output logic [3:0]  AN,
  output logic [3:0]  hex,
  output logic        point,
  output logic        LE,
  output logic        frame_done,
  output logic        load_ack
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;
  logic [1:0]    sel;
  logic [15:0]   act_data, pend_data;
  logic [3:0]    act_point, pend_point;
  logic [3:0]    act_le, pend_le;
  logic          pend;
  logic          blank_q;

  logic          tick;
  logic          boundary;
  logic          transfer;
  logic [1:0]    sel_n;
  logic [15:0]   data_n;
  logic [3:0]    point_n;
  logic [3:0]    le_n;

  // Outputs are registered from the next-state values so they move on the
  // same edge as sel/active/blank_q without any input-to-output path.
  always_comb begin
    tick     = (cnt == CW'(DIV - 1));
    boundary = tick && (sel == 2'd3);
    transfer = boundary && pend;
    sel_n    = tick ? sel + 2'd1 : sel;
    data_n   = transfer ? pend_data  : act_data;
    point_n  = transfer ? pend_point : act_point;
    le_n     = transfer ? pend_le    : act_le;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      sel        <= 2'd0;
      act_data   <= 16'h0000;
      act_point  <= 4'h0;
      act_le     <= 4'hF;
      pend_data  <= 16'h0000;
      pend_point <= 4'h0;
      pend_le    <= 4'h0;
      pend       <= 1'b0;
      blank_q    <= 1'b0;
      AN         <= 4'b1110;
      hex        <= 4'h0;
      point      <= 1'b0;
      LE         <= 1'b1;
      frame_done <= 1'b0;
      load_ack   <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + 1'b1;
      sel        <= sel_n;
      act_data   <= data_n;
      act_point  <= point_n;
      act_le     <= le_n;
      blank_q    <= blank;
      frame_done <= boundary;
      load_ack   <= transfer;
      // A load landing on the boundary stays pending after the old copy moves.
      if (load) begin
        pend_data  <= data_in;
        pend_point <= point_in;
        pend_le    <= le_in;
        pend       <= 1'b1;
      end else if (boundary) begin
        pend       <= 1'b0;
      end
      AN    <= blank ? 4'b1111 : ~(4'b0001 << sel_n);
      hex   <= data_n[{sel_n, 2'b00} +: 4];
      point <= point_n[sel_n];
      LE    <= le_n[sel_n] | blank;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// tb/tb_display_scan.sv - randomized and directed check of display_scan against a frame-level reference model
module tb_display_scan;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  point_in = '0;
  logic [3:0]  le_in = '0;
  logic        blank = 1'b0;
  logic [3:0]  AN, hex;
  logic        point, LE, frame_done, load_ack;

  int errors = 0;
  int checks = 0;

  int          n;
  logic [15:0] m_data, p_data;
  logic [3:0]  m_point, m_le, p_point, p_le;
  bit          m_pend, m_bq, e_fd, e_ack;

  display_scan #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .point_in(point_in),
    .le_in(le_in), .blank(blank), .AN(AN), .hex(hex), .point(point), .LE(LE),
    .frame_done(frame_done), .load_ack(load_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0; m_data = 0; m_point = 0; m_le = 4'hF;
    m_pend = 0; m_bq = 0; e_fd = 0; e_ack = 0;
  endtask

  // Digit slot is time since reset divided into DIV-cycle slots; a frame is four slots.
  task automatic model_edge();
    bit bnd;
    n++;
    bnd   = (n % (4 * DIV)) == 0;
    e_fd  = bnd;
    e_ack = bnd && m_pend;
    if (e_ack) begin
      m_data = p_data; m_point = p_point; m_le = p_le;
    end
    if (load) begin
      p_data = data_in; p_point = point_in; p_le = le_in; m_pend = 1;
    end else if (bnd) begin
      m_pend = 0;
    end
    m_bq = blank;
  endtask

  task automatic check_all();
    int s;
    logic [3:0] e_an, e_hex;
    s     = (n / DIV) % 4;
    e_an  = m_bq ? 4'b1111 : ~(4'b0001 << s);
    e_hex = (m_data >> (4 * s)) & 16'hF;
    chk("AN", AN, e_an);
    chk("hex", hex, e_hex);
    chk("point", point, m_point[s]);
    chk("LE", LE, m_le[s] | m_bq);
    chk("frame_done", frame_done, e_fd);
    chk("load_ack", load_ack, e_ack);
    chk("an_onehot", ($countones(~AN) <= 1), 1'b1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic steps(int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic do_load(logic [15:0] d, logic [3:0] p, logic [3:0] l);
    load = 1; data_in = d; point_in = p; le_in = l;
    step();
    load = 0;
  endtask

  task automatic async_reset();
    rst = 1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    @(negedge clk);
    model_reset();
    check_all();
    rst = 0;

    // Scan pattern with a decimal point on digit 1
    do_load(16'h1234, 4'b0010, 4'b0000);
    steps(4 * 4 * DIV);

    // Two loads in one frame: last wins, one acknowledge
    do_load(16'hAAAA, 4'b0000, 4'b0000);
    steps(2);
    do_load(16'hBBBB, 4'b0000, 4'b0000);
    steps(2 * 4 * DIV);

    // Load in the boundary cycle with nothing pending
    while (((n + 1) % (4 * DIV)) != 0) step();
    do_load(16'h5555, 4'b0000, 4'b0000);
    steps(2 * 4 * DIV);

    // Blank for six cycles mid-scan
    steps(3);
    blank = 1;
    steps(6);
    blank = 0;
    steps(4 * DIV);

    // Per-digit blank on digit 2
    do_load(16'h9876, 4'b1000, 4'b0100);
    steps(2 * 4 * DIV);

    // Reset mid-frame discards pending content
    do_load(16'hCAFE, 4'b1111, 4'b0000);
    steps(3);
    async_reset();
    steps(2 * 4 * DIV);

    // Randomized loads and blanking
    for (int i = 0; i < 400; i++) begin
      load     = ($urandom_range(0, 9) == 0);
      data_in  = 16'($urandom);
      point_in = 4'($urandom);
      le_in    = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blank = ~blank;
      step();
    end
    load = 0;
    blank = 0;
    steps(4 * DIV);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
